ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Upstream feeder of the FPGA fabric configuration port. Accepts configuration bit-columns over a valid/ready stream and shifts them into NUM_CHAINS parallel configuration-chain heads.
- Generates the programming clock and config_enable, and asserts cfg_done once exactly CHAIN_LEN bits per chain are loaded.
- Replaces force-based bitstream preload in fabric-level benches and bring-up, so the fabric sees real shift loading.

Parameters:
- NUM_CHAINS, 10, number of parallel configuration chains (one data bit per chain per shift)
- CHAIN_LEN, 1024, shifts per chain required to complete configuration
- HALF_PERIOD, 2, clk cycles per prog_clock phase (>=1)
- TIMEOUT, 4096, max clk cycles waiting for input data before error (0 = disabled)

Ports:
- clk  input  1  system clock
- global_reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begins a load; honoured only in IDLE, DONE or ERROR
- s_valid  input  1  column valid
- s_ready  output  1  column accepted when s_valid && s_ready
- s_data  input  NUM_CHAINS  bit i goes to chain i
- ccff_head  output  NUM_CHAINS  chain head data, registered
- prog_clock  output  1  programming clock, registered, idle low
- config_enable  output  1  high for the whole load
- cfg_done  output  1  sticky completion flag
- cfg_error  output  1  sticky timeout flag
- bit_count  output  clog2(CHAIN_LEN+1)  shifts completed so far

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE.
  - All outputs 0: s_ready, ccff_head, prog_clock, config_enable, cfg_done, cfg_error, bit_count.
  - Phase counter and timeout counter cleared.
  - Reset mid-load abandons the load; no partial cfg_done.
- IDLE: on start, go to WAIT.
  - config_enable=1; cfg_done=0, cfg_error=0, bit_count=0.
- WAIT:
  - s_ready=1, prog_clock=0.
  - On handshake: ccff_head<=s_data, s_ready drops the next cycle, go to SETUP.
  - Timeout counter increments each WAIT cycle without handshake and clears on handshake.
  - When the counter reaches TIMEOUT, go to ERROR.
- SETUP: hold HALF_PERIOD cycles with prog_clock=0 (data setup to fabric), then go to HIGH.
- HIGH:
  - prog_clock=1 for HALF_PERIOD cycles.
  - On exit, prog_clock returns to 0 and bit_count increments.
  - If the new bit_count==CHAIN_LEN, go to DONE; otherwise go to WAIT.
- DONE:
  - config_enable=0, cfg_done=1, s_ready=0.
  - ccff_head holds its last value; bit_count holds CHAIN_LEN.
  - Stays until start, which begins a new load as from IDLE.
- ERROR:
  - config_enable=0, cfg_error=1, s_ready=0.
  - Exits only on start, which behaves as from IDLE.
- start in WAIT, SETUP or HIGH is ignored.
- s_valid outside WAIT is ignored; data is not consumed.
- Throughput with s_valid held high: one column per 2*HALF_PERIOD+1 clk cycles.
- Full load takes CHAIN_LEN*(2*HALF_PERIOD+1) cycles from the first handshake to cfg_done.
- prog_clock is glitch-free: it is driven only from a flop, and rising edges are always at least HALF_PERIOD cycles after a ccff_head update.
- bit_count never wraps; it saturates at CHAIN_LEN.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - State enum: IDLE, WAIT, SETUP, HIGH, DONE, ERROR.
  - A function computing the counter widths.
- One natural sub-module, ccff_phase_timer: a loadable down-counter that issues a terminal-count pulse after HALF_PERIOD cycles. It is reused for the SETUP and HIGH phases.
- Everything else lives in the top module.

Test Plan:
- NUM_CHAINS=10, CHAIN_LEN=4, HALF_PERIOD=2. Stimulus: start, then columns 0x3FF, 0x000, 0x155, 0x2AA with s_valid always high.
  - Exactly 4 prog_clock rising edges.
  - ccff_head is stable for 2 cycles before each rise.
  - cfg_done rises 20 cycles after the first handshake; config_enable falls in the same cycle.
- Same configuration with s_valid deasserted for 7 cycles between columns 2 and 3.
  - prog_clock stays low and state stays WAIT during the gap.
  - Load completes with bit_count=4, cfg_done=1.
- TIMEOUT=8, start, no s_valid.
  - cfg_error=1 and config_enable=0 after 8 cycles; s_ready=0.
  - A following start with 4 columns reaches cfg_done=1 with cfg_error=0.
- Assert global_reset_n low after the 2nd prog_clock rise.
  - All outputs are 0 immediately (asynchronous), bit_count=0.
  - After release, a fresh start loads 4 columns normally.
- Pulse start during HIGH, and drive s_valid in DONE.
  - The start is ignored; the load finishes on schedule.
  - In DONE, s_ready=0 and no further prog_clock edges occur.
- Pulse start in DONE.
  - cfg_done clears the next cycle, config_enable=1, bit_count=0.
  - A second full 4-column load completes.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StSetup,
    StHigh,
    StDone,
    StError
  } ccff_state_e;

  // Bits needed to hold any value in 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Valid/ready column stream feeding the configuration-chain loader.
interface ccff_chain_loader_if #(
  parameter int unsigned NUM_CHAINS = 10
);
  logic                  s_valid;
  logic                  s_ready;
  logic [NUM_CHAINS-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/ccff_phase_timer.sv
// Loadable down-counter; tc pulses on the last cycle of a HALF_PERIOD-long phase.
module ccff_phase_timer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = cnt_width(HALF_PERIOD - 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(HALF_PERIOD - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tc = en && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Shifts streamed configuration columns into parallel chain heads, generating prog_clock,
// config_enable and sticky done/error flags.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned NUM_CHAINS  = 10,
  parameter int unsigned CHAIN_LEN   = 1024,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                              clk,
  input  logic                              global_reset_n,
  input  logic                              start,
  ccff_chain_loader_if.slave                s_bus,
  output logic [NUM_CHAINS-1:0]             ccff_head,
  output logic                              prog_clock,
  output logic                              config_enable,
  output logic                              cfg_done,
  output logic                              cfg_error,
  output logic [cnt_width(CHAIN_LEN)-1:0]   bit_count
);

  localparam int unsigned BcW = cnt_width(CHAIN_LEN);
  localparam int unsigned ToW = cnt_width(TIMEOUT);
  localparam int unsigned ToLastInt = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [BcW-1:0] BcLast = BcW'(CHAIN_LEN);
  localparam logic [ToW-1:0] ToLast = ToW'(ToLastInt);

  ccff_state_e           state_q, state_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic [BcW-1:0]        bit_count_q, bit_count_d;
  logic [ToW-1:0]        timeout_q, timeout_d;
  logic                  prog_clock_q;
  logic                  phase_load, phase_en, phase_tc;

  assign phase_en = (state_q == StSetup) || (state_q == StHigh);

  ccff_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_timer (
    .clk  (clk),
    .rst_n(global_reset_n),
    .load (phase_load),
    .en   (phase_en),
    .tc   (phase_tc)
  );

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    bit_count_d = bit_count_q;
    timeout_d   = '0;
    phase_load  = 1'b0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d     = StWait;
          bit_count_d = '0;
        end
      end
      StWait: begin
        // s_ready is high throughout WAIT, so s_valid alone is a handshake.
        if (s_bus.s_valid) begin
          head_d     = s_bus.s_data;
          phase_load = 1'b1;
          state_d    = StSetup;
        end else if (TIMEOUT != 0) begin
          if (timeout_q == ToLast) begin
            state_d = StError;
          end else begin
            timeout_d = timeout_q + ToW'(1);
          end
        end
      end
      StSetup: begin
        if (phase_tc) begin
          phase_load = 1'b1;
          state_d    = StHigh;
        end
      end
      StHigh: begin
        if (phase_tc) begin
          if (bit_count_q != BcLast) begin
            bit_count_d = bit_count_q + BcW'(1);
          end
          state_d = (bit_count_d == BcLast) ? StDone : StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q      <= StIdle;
      head_q       <= '0;
      bit_count_q  <= '0;
      timeout_q    <= '0;
      prog_clock_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      bit_count_q  <= bit_count_d;
      timeout_q    <= timeout_d;
      prog_clock_q <= (state_d == StHigh);
    end
  end

  assign s_bus.s_ready = (state_q == StWait);
  assign config_enable = (state_q == StWait) || (state_q == StSetup) || (state_q == StHigh);
  assign cfg_done      = (state_q == StDone);
  assign cfg_error     = (state_q == StError);
  assign ccff_head     = head_q;
  assign prog_clock    = prog_clock_q;
  assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed self-checking bench for ccff_chain_loader (4-deep chains, 2-cycle half period).
module tb_ccff_chain_loader;

  localparam int unsigned NC = 10;
  localparam int unsigned CL = 4;
  localparam int unsigned HP = 2;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          global_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [NC-1:0] ccff_head;
  logic          prog_clock;
  logic          config_enable;
  logic          cfg_done;
  logic          cfg_error;
  logic [2:0]    bit_count;

  ccff_chain_loader_if #(.NUM_CHAINS(NC)) bus ();

  ccff_chain_loader #(
    .NUM_CHAINS (NC),
    .CHAIN_LEN  (CL),
    .HALF_PERIOD(HP),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .global_reset_n(global_reset_n),
    .start         (start),
    .s_bus         (bus),
    .ccff_head     (ccff_head),
    .prog_clock    (prog_clock),
    .config_enable (config_enable),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rises, min_setup, hs_first, hs_count, done_cyc, ce_fall, head_chg;
  logic pc_prev, ce_prev, done_prev;
  logic [NC-1:0] head_prev;
  logic [NC-1:0] cols [4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
  logic gap_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: note a handshake due at the coming edge, then observe at the falling edge.
  task automatic step();
    if (bus.s_valid && bus.s_ready) begin
      hs_count++;
      if (hs_first < 0) hs_first = cyc;
    end
    @(negedge clk);
    cyc++;
    if (prog_clock && !pc_prev) begin
      rises++;
      if (cyc - head_chg < min_setup) min_setup = cyc - head_chg;
    end
    if (ccff_head != head_prev) head_chg = cyc;
    if (cfg_done && !done_prev) done_cyc = cyc;
    if (!config_enable && ce_prev) ce_fall = cyc;
    pc_prev   = prog_clock;
    ce_prev   = config_enable;
    done_prev = cfg_done;
    head_prev = ccff_head;
  endtask

  task automatic clear_stats();
    rises = 0; min_setup = 1000; hs_first = -1; hs_count = 0;
    done_cyc = -1; ce_fall = -1; head_chg = cyc;
    pc_prev = prog_clock; ce_prev = config_enable;
    done_prev = cfg_done; head_prev = ccff_head;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [NC-1:0] d);
    int n;
    n = hs_count;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 40 && hs_count == n; i++) step();
    chk("feed_handshake", hs_count, n + 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !cfg_done; i++) step();
    chk("done_reached", cfg_done, 1);
  endtask

  task automatic load_all();
    for (int k = 0; k < 4; k++) feed(cols[k]);
    wait_done();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    clear_stats();

    // Reset state
    step(); step();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_prog_clock", prog_clock, 0);
    chk("rst_cfg_en", config_enable, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_bit_count", bit_count, 0);
    global_reset_n = 1'b1;
    step();

    // Basic load, s_valid always high
    clear_stats();
    pulse_start();
    chk("t1_cfg_en", config_enable, 1);
    chk("t1_s_ready", bus.s_ready, 1);
    chk("t1_bit_count0", bit_count, 0);
    feed(cols[0]);
    chk("t1_head0", ccff_head, 10'h3FF);
    chk("t1_ready_drop", bus.s_ready, 0);
    for (int k = 1; k < 4; k++) feed(cols[k]);
    wait_done();
    chk("t1_rises", rises, 4);
    chk("t1_min_setup", min_setup, 2);
    chk("t1_done_latency", done_cyc - hs_first, 20);
    chk("t1_cfg_en_fall", ce_fall, done_cyc);
    chk("t1_bit_count", bit_count, 4);
    chk("t1_head_last", ccff_head, 10'h2AA);
    chk("t1_no_error", cfg_error, 0);
    // s_valid stays high in DONE and must be ignored
    repeat (10) step();
    chk("t1_done_rises", rises, 4);
    chk("t1_done_hs", hs_count, 4);
    chk("t1_done_ready", bus.s_ready, 0);
    chk("t1_done_pc", prog_clock, 0);
    chk("t1_done_sticky", cfg_done, 1);
    chk("t1_done_bc", bit_count, 4);

    // Restart from DONE, then a 7-cycle gap before column 3
    bus.s_valid = 1'b0;
    clear_stats();
    pulse_start();
    chk("t6_done_clr", cfg_done, 0);
    chk("t6_cfg_en", config_enable, 1);
    chk("t6_bit_count", bit_count, 0);
    for (int k = 0; k < 3; k++) feed(cols[k]);
    bus.s_valid = 1'b0;
    repeat (4) step();
    gap_ok = bus.s_ready && !prog_clock;
    for (int i = 0; i < 7; i++) begin
      step();
      if (!(bus.s_ready && !prog_clock)) gap_ok = 1'b0;
    end
    chk("t2_gap_wait", gap_ok, 1);
    chk("t2_gap_rises", rises, 3);
    chk("t2_gap_no_err", cfg_error, 0);
    feed(cols[3]);
    wait_done();
    chk("t2_bit_count", bit_count, 4);
    chk("t2_rises", rises, 4);
    chk("t2_no_error", cfg_error, 0);

    // start pulsed during HIGH is ignored
    bus.s_valid = 1'b0;
    clear_stats();
    pulse_start();
    feed(cols[0]);
    step(); step();
    chk("t5_in_high", prog_clock, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_still_loading", config_enable, 1);
    chk("t5_bc_kept", bit_count, 0);
    for (int k = 1; k < 4; k++) feed(cols[k]);
    wait_done();
    chk("t5_latency", done_cyc - hs_first, 20);
    chk("t5_rises", rises, 4);
    repeat (8) step();
    chk("t5_done_rises", rises, 4);
    chk("t5_done_ready", bus.s_ready, 0);
    chk("t5_done_hs", hs_count, 4);

    // Timeout with no data
    bus.s_valid = 1'b0;
    clear_stats();
    pulse_start();
    repeat (7) step();
    chk("t3_pre_err", cfg_error, 0);
    chk("t3_pre_ready", bus.s_ready, 1);
    step();
    chk("t3_error", cfg_error, 1);
    chk("t3_cfg_en", config_enable, 0);
    chk("t3_ready", bus.s_ready, 0);
    chk("t3_no_done", cfg_done, 0);
    clear_stats();
    pulse_start();
    chk("t3_err_clr", cfg_error, 0);
    load_all();
    chk("t3_reload_done", cfg_done, 1);
    chk("t3_reload_err", cfg_error, 0);
    chk("t3_reload_bc", bit_count, 4);

    // Asynchronous reset mid-load
    bus.s_valid = 1'b0;
    clear_stats();
    pulse_start();
    feed(cols[0]);
    feed(cols[1]);
    for (int i = 0; i < 20 && rises < 2; i++) step();
    chk("t4_two_rises", rises, 2);
    bus.s_valid = 1'b0;
    #2 global_reset_n = 1'b0;
    #1;
    chk("t4_s_ready", bus.s_ready, 0);
    chk("t4_head", ccff_head, 0);
    chk("t4_prog_clock", prog_clock, 0);
    chk("t4_cfg_en", config_enable, 0);
    chk("t4_done", cfg_done, 0);
    chk("t4_error", cfg_error, 0);
    chk("t4_bit_count", bit_count, 0);
    step();
    global_reset_n = 1'b1;
    step();
    clear_stats();
    pulse_start();
    load_all();
    chk("t4_reload_bc", bit_count, 4);
    chk("t4_reload_rises", rises, 4);
    chk("t4_reload_head", ccff_head, 10'h2AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
